dly_tap_ctrl: RTL

Tap-value controller that drives the delay-line control interface (DLY_LOAD / DLY_ADJ / DLY_INCDEC, with DLY_TAP_VALUE read back) of an output or input delay primitive. On request, it optionally reloads the primitive's DELAY parameter, then issues adjust pulses until the read-back tap equals a requested target. It sits in fabric next to the delay primitive, on the primitive's clock, and hides the primitive's two-flop edge-detect pulse rules from calibration logic.

---
 rtl/dly_tap_ctrl.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dly_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dly_tap_ctrl
// Purpose  : Tap-value controller for the load/adjust control interface of an
//            input or output delay primitive. On request it optionally pulses
//            DLY_LOAD, then issues DLY_ADJ pulses until the tap read back
//            from the primitive equals the requested target. Every pulse is
//            PULSE_W cycles high and GAP_W cycles low, so the primitive's
//            two-flop edge detector sees exactly one rising edge per pulse.
//            Each tap update also settles before the next compare.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   DLY_TAP_CTRL_TIMEOUT_EN  - when defined, adds the adjust-step limit
//                              (MAX_STEPS) and stuck-tap detection. A failed
//                              request ends with a sticky error_o. When not
//                              defined, error_o is tied low and the
//                              controller adjusts until the tap matches.
// ----------------------------------------------------------------------------
// Parameters:
//   PULSE_W    cycles DLY_LOAD / DLY_ADJ are held high per pulse (2..15)
//   GAP_W      cycles held low after each pulse before read-back (3..15)
//   MAX_STEPS  adjust pulses allowed per request (timeout build, 1..255)
// Ports:
//   clk_i            clock shared with the delay primitive
//   rst_ni           asynchronous active-low reset
//   start_i          request, sampled only while idle
//   load_req_i       sampled with start_i, 1 = load pulse before adjusting
//   target_i[5:0]    requested tap, latched when a request is accepted
//   dly_tap_value_i  tap value read back from the primitive
//   dly_load_o       load pulse to the primitive
//   dly_adj_o        adjust pulse to the primitive
//   dly_incdec_o     adjust direction to the primitive, 1 = increment
//   busy_o           high from accept until done_o / error_o
//   done_o           one-cycle pulse, tap equals target
//   error_o          sticky failure flag, cleared by the next accepted start
// ============================================================================
module dly_tap_ctrl #(
    parameter int PULSE_W   = 2,
    parameter int GAP_W     = 3,
    parameter int MAX_STEPS = 70
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       load_req_i,
    input  logic [5:0] target_i,
    input  logic [5:0] dly_tap_value_i,
    output logic       dly_load_o,
    output logic       dly_adj_o,
    output logic       dly_incdec_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_HI = 3'd1;
    localparam logic [2:0] S_LOAD_LO = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_ADJ_HI  = 3'd4;
    localparam logic [2:0] S_ADJ_LO  = 3'd5;
    localparam logic [2:0] S_FINISH  = 3'd6;
    localparam logic [2:0] S_FAIL    = 3'd7;

    // Last count value of the high and low phases of a pulse.
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_W - 1);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [5:0] target_q;
    logic [5:0] target_d;

    logic       dly_load_q;
    logic       dly_load_d;
    logic       dly_adj_q;
    logic       dly_adj_d;
    logic       dly_incdec_q;
    logic       dly_incdec_d;
    logic       busy_q;
    logic       busy_d;
    logic       done_q;
    logic       done_d;

    logic       w_accept;
    logic       w_tap_eq;
    logic       w_tap_below;
    logic       w_fail;

    // A request is only taken while idle; start_i is ignored otherwise.
    assign w_accept    = (state_q == S_IDLE) && start_i;
    assign w_tap_eq    = (dly_tap_value_i == target_q);
    assign w_tap_below = (dly_tap_value_i < target_q);

    // ------------------------------------------------------------------------
    // Optional timeout / stuck-tap supervision
    // ------------------------------------------------------------------------
`ifdef DLY_TAP_CTRL_TIMEOUT_EN
    localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);

    logic [7:0] step_q;
    logic [7:0] step_d;
    logic [5:0] prev_tap_q;
    logic [5:0] prev_tap_d;
    logic       error_q;
    logic       error_d;

    always_comb begin
        step_d     = step_q;
        prev_tap_d = prev_tap_q;
        error_d    = error_q;
        if (w_accept) begin
            step_d  = 8'd0;
            error_d = 1'b0;
        end else begin
            // Count adjust pulses on entry to the high phase, saturating.
            if ((state_q != S_ADJ_HI) && (state_d == S_ADJ_HI) && (step_q != 8'hFF)) begin
                step_d = step_q + 8'd1;
            end
            if (state_q == S_FAIL) begin
                error_d = 1'b1;
            end
        end
        if (state_q == S_CHECK) begin
            prev_tap_d = dly_tap_value_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            step_q     <= 8'd0;
            prev_tap_q <= 6'd0;
            error_q    <= 1'b0;
        end else begin
            step_q     <= step_d;
            prev_tap_q <= prev_tap_d;
            error_q    <= error_d;
        end
    end

    // Every CHECK after the first adjust of a request follows an adjust, so
    // a nonzero step count means prev_tap_q holds the pre-adjust tap. An
    // unchanged tap then means the primitive did not respond.
    assign w_fail  = (step_q == STEP_LIMIT) ||
                     ((step_q != 8'd0) && (dly_tap_value_i == prev_tap_q));
    assign error_o = error_q;
`else
    assign w_fail  = 1'b0;
    assign error_o = 1'b0;

    // The step limit only matters with supervision built in; this empty
    // block keeps the parameter referenced so both builds share one
    // parameter list.
    if (MAX_STEPS < 1) begin : g_step_limit_unused
    end
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            target_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        if (w_accept) begin
            target_d = target_i;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = load_req_i ? S_LOAD_HI : S_CHECK;
                end
            end
            S_LOAD_HI: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_LOAD_LO;
                end
            end
            S_LOAD_LO: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_tap_eq) begin
                    state_d = S_FINISH;
                end else if (w_fail) begin
                    state_d = S_FAIL;
                end else begin
                    state_d = S_ADJ_HI;
                end
            end
            S_ADJ_HI: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_ADJ_LO;
                end
            end
            S_ADJ_LO: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_CHECK;
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_FAIL:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Phase counter restarts on every state change; it only matters in
        // the four timed pulse phases.
        cnt_d = (state_d == state_q) ? (cnt_q + 4'd1) : 4'd0;
    end

    // ------------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------------
    // Outputs follow the registered state one cycle later, so the pulse
    // widths on the pins equal the time spent in LOAD_HI / ADJ_HI and the
    // two pulse outputs can never be high together.
    always_comb begin
        dly_load_d   = (state_q == S_LOAD_HI);
        dly_adj_d    = (state_q == S_ADJ_HI);
        done_d       = (state_q == S_FINISH);

        busy_d = busy_q;
        if (w_accept) begin
            busy_d = 1'b1;
        end else if ((state_q == S_FINISH) || (state_q == S_FAIL)) begin
            busy_d = 1'b0;
        end

        // Direction is only decided in CHECK when an adjust follows, and is
        // therefore stable through the whole adjust pulse and its gap.
        dly_incdec_d = dly_incdec_q;
        if ((state_q == S_CHECK) && (state_d == S_ADJ_HI)) begin
            dly_incdec_d = w_tap_below;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dly_load_q   <= 1'b0;
            dly_adj_q    <= 1'b0;
            dly_incdec_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            dly_load_q   <= dly_load_d;
            dly_adj_q    <= dly_adj_d;
            dly_incdec_q <= dly_incdec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign dly_load_o   = dly_load_q;
    assign dly_adj_o    = dly_adj_q;
    assign dly_incdec_o = dly_incdec_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
`default_nettype wire
